// File: rtl/dff_with_and_gate.sv
// ----------------------------------------------------------------------------
// dff_with_and_gate
//
// Registered bitwise AND of two WIDTH-bit operands. q is driven straight from
// a single WIDTH-bit register, so downstream logic sees a glitch-free result
// that is aligned to clk. The result appears one cycle after a/b are sampled.
//
// Reset is synchronous and active-high, and it loads RESET_VAL.
//
// Optional feature (build-time macro):
//   DFF_AND_CE_EN - adds the clock-enable input ce. When ce is low on a
//                   non-reset edge, q holds its value. Reset still wins
//                   over ce.
// ----------------------------------------------------------------------------
module dff_with_and_gate #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef DFF_AND_CE_EN
    input  logic             ce,
`endif
    output logic [WIDTH-1:0] q
);

    // Load qualifier: ce when the enable feature is built in, otherwise always load.
    logic load_en;

`ifdef DFF_AND_CE_EN
    assign load_en = ce;
`else
    assign load_en = 1'b1;
`endif

    // Single register stage: reset > enable > data load.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RESET_VAL;
        end else if (load_en) begin
            q <= a & b;
        end
    end

endmodule

// File: tb/tb_dff_with_and_gate.sv
// ----------------------------------------------------------------------------
// tb_dff_with_and_gate
//
// Self-checking bench for dff_with_and_gate. It builds two instances:
//   u_dut1 - WIDTH=1 with the default RESET_VAL
//   u_dut8 - WIDTH=8 with RESET_VAL=8'h5A
// Each edge, the expected q comes from the behavioural rules: reset loads
// RESET_VAL, an enabled edge loads a AND b, and any other edge holds q.
// Build with +define+DFF_AND_CE_EN to exercise the ce input.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_dff_with_and_gate;

    localparam logic [7:0] RV8 = 8'h5A;

    logic       clk = 1'b0;
    logic       reset;
    logic       ce;
    logic       a1, b1, q1;
    logic [7:0] a8, b8, q8;

    logic       exp1;
    logic [7:0] exp8;

    int checks = 0;
    int passed = 0;

    // 10 ns clock
    always #5 clk = ~clk;

    dff_with_and_gate #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .a     (a1),
        .b     (b1),
`ifdef DFF_AND_CE_EN
        .ce    (ce),
`endif
        .q     (q1)
    );

    dff_with_and_gate #(.WIDTH(8), .RESET_VAL(RV8)) u_dut8 (
        .clk   (clk),
        .reset (reset),
        .a     (a8),
        .b     (b8),
`ifdef DFF_AND_CE_EN
        .ce    (ce),
`endif
        .q     (q8)
    );

    // Counts one comparison and reports it if it does not match.
    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got === want) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Applies the next edge, updates the model, then checks both DUTs 1 ns after the edge.
    task automatic tick(input string tag);
        logic       nxt1;
        logic [7:0] nxt8;
        if (reset) begin
            nxt1 = 1'b0;
            nxt8 = RV8;
        end else if (ce) begin
            // Each bit of q is 1 only where both operands are 1.
            nxt1 = a1 & b1;
            for (int i = 0; i < 8; i++) nxt8[i] = (a8[i] + b8[i] == 2);
        end else begin
            nxt1 = exp1;
            nxt8 = exp8;
        end
        @(posedge clk);
        #1;
        exp1 = nxt1;
        exp8 = nxt8;
        check(tag, {7'b0, q1}, {7'b0, exp1});
        check({tag, "_w8"}, q8, exp8);
    endtask

    initial begin
        reset = 1'b1;
        ce    = 1'b1;
        a1    = 1'b0;
        b1    = 1'b0;
        a8    = 8'hFF;
        b8    = 8'hFF;
        exp1  = 1'bx;
        exp8  = 'x;

        // 1. Reset, then release with zero operands
        tick("reset");
        reset = 1'b0;
        a8 = 8'h00;
        tick("release_zero");

        // 2. Truth table
        a1 = 1'b0; b1 = 1'b1; a8 = 8'hF0; b8 = 8'h3C; tick("tt_01");
        a1 = 1'b1; b1 = 1'b0; a8 = 8'hAA; b8 = 8'h55; tick("tt_10");
        a1 = 1'b1; b1 = 1'b1; a8 = 8'hFF; b8 = 8'hC3; tick("tt_11");

        // 3. Latency: inputs change mid-cycle and q must not follow until the next edge
        a1 = 1'b0; b1 = 1'b0; a8 = 8'h00; tick("lat_pre");
        #3;
        a1 = 1'b1; b1 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
        #1;
        check("lat_mid", {7'b0, q1}, 8'h00);
        check("lat_mid_w8", q8, 8'h00);
        tick("lat_edge");

        // 4. Reset asserted mid-cycle: q holds until the edge, then stays at RESET_VAL
        #3;
        reset = 1'b1;
        #1;
        check("rst_mid", {7'b0, q1}, 8'h01);
        check("rst_mid_w8", q8, 8'hFF);
        tick("rst_edge");
        tick("rst_hold");
        tick("rst_hold2");

        // 5. Reset released with a=b=1: the first edge loads the result immediately
        reset = 1'b0;
        tick("rst_release");

`ifdef DFF_AND_CE_EN
        // 6. Clock enable holds q, and reset overrides ce
        ce = 1'b0; a1 = 1'b0; a8 = 8'h0F; tick("ce_hold");
        ce = 1'b1; tick("ce_load");
        a1 = 1'b1; a8 = 8'hFF; tick("ce_reload");
        reset = 1'b1; ce = 1'b0; tick("ce_rst_over");
        reset = 1'b0; tick("ce_after_rst");
`endif

        // Randomized phase
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 9) == 0);
            a1    = 1'($urandom);
            b1    = 1'($urandom);
            a8    = 8'($urandom);
            b8    = 8'($urandom);
`ifdef DFF_AND_CE_EN
            ce    = ($urandom_range(0, 3) != 0);
`endif
            tick("rand");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
